// File: rtl/fibo_scroller_pkg.sv
// Shared types and constants for the Fibonacci table scroller.
package fibo_scroller_pkg;

  typedef enum logic [1:0] {
    ST_GEN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  // Idle banner, char 0 in the top byte.
  localparam logic [127:0] BANNER_A = "Press BTN3 to   ";
  localparam logic [127:0] BANNER_B = "show a message..";

  // Shown right-aligned in place of the value when an entry overflowed.
  localparam logic [23:0] OVF_STR = "OVF";

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // One nibble to its uppercase hex ASCII character.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] d);
    if (d < 4'd10) return 8'h30 + {4'h0, d};
    else           return 8'h37 + {4'h0, d};
  endfunction

endpackage

// File: rtl/fibo_table.sv
// Fibonacci table: generates F(0..N-1) at W bits after reset, marks overflow
// (sticky forward), then serves two combinational read ports.
module fibo_table
  import fibo_scroller_pkg::*;
#(
  parameter int N  = 25,
  parameter int W  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd0_addr_i,
  input  logic [AW-1:0] rd1_addr_i,
  output logic [W-1:0]  rd0_data_o,
  output logic [W-1:0]  rd1_data_o,
  output logic          rd0_ovf_o,
  output logic          rd1_ovf_o,
  output logic          ready_o,
  output logic          ovf_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  logic [W-1:0]  mem_q [N];
  logic [N-1:0]  ovf_bits_q;
  logic [AW-1:0] gen_idx_q;
  logic          ready_q;
  logic          ovf_q;

  logic [AW-1:0] idx_m1;
  logic [AW-1:0] idx_m2;
  logic [W:0]    sum;
  logic          prev_ovf;
  logic          new_ovf;
  logic [W-1:0]  new_val;

  // Next entry from the two previous ones; once any entry overflowed, all later ones read 0 + OVF.
  always_comb begin
    idx_m1   = gen_idx_q - AW'(1);
    idx_m2   = gen_idx_q - AW'(2);
    sum      = {1'b0, mem_q[idx_m1]} + {1'b0, mem_q[idx_m2]};
    prev_ovf = ovf_bits_q[idx_m1];
    new_ovf  = sum[W] | prev_ovf;
    new_val  = prev_ovf ? '0 : sum[W-1:0];
  end

  // Generation index, completion flag and summary overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_idx_q <= FIRST_IDX;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (!ready_q) begin
      if (gen_idx_q == LAST_IDX) ready_q <= 1'b1;
      else                       gen_idx_q <= gen_idx_q + 1'b1;
      if (gen_idx_q != FIRST_IDX && new_ovf) ovf_q <= 1'b1;
    end
  end

  // Table storage; contents are meaningless until ready, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!ready_q) begin
      if (gen_idx_q == FIRST_IDX) begin
        mem_q[0]      <= '0;
        mem_q[1]      <= W'(1);
        ovf_bits_q[0] <= 1'b0;
        ovf_bits_q[1] <= 1'b0;
      end else begin
        mem_q[gen_idx_q]      <= new_val;
        ovf_bits_q[gen_idx_q] <= new_ovf;
      end
    end
  end

  assign rd0_data_o = mem_q[rd0_addr_i];
  assign rd1_data_o = mem_q[rd1_addr_i];
  assign rd0_ovf_o  = ovf_bits_q[rd0_addr_i];
  assign rd1_ovf_o  = ovf_bits_q[rd1_addr_i];
  assign ready_o    = ready_q;
  assign ovf_o      = ovf_q;
  // High on the cycle whose edge writes the final entry.
  assign last_o     = !ready_q && (gen_idx_q == LAST_IDX);

endmodule

// File: rtl/fibo_scroller.sv
// Two-row LCD scroller over a generated Fibonacci table. Buttons arrive as
// one-cycle pulses; rows are registered and lag index/state by one edge.
module fibo_scroller
  import fibo_scroller_pkg::*;
#(
  parameter int N      = 25,
  parameter int W      = 16,
  parameter int PERIOD = 70000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dir_pulse,
  input  logic         pause_pulse,
  input  logic         step_pulse,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         ready,
  output logic         ovf,
  output logic         running,
  output logic         reverse
);

  localparam int AW     = $clog2(N);
  localparam int CW     = $clog2(PERIOD);
  localparam int DIGITS = W / 4;
  localparam logic [AW-1:0] LAST_IDX   = AW'(N - 1);
  localparam logic [CW-1:0] PERIOD_MAX = CW'(PERIOD - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] t_q, t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rev_q, rev_d;
  logic [127:0]  row_a_q, row_a_d;
  logic [127:0]  row_b_q, row_b_d;
  logic          do_step;

  logic [AW-1:0] t_b;
  logic [W-1:0]  rd0_data, rd1_data;
  logic          rd0_ovf, rd1_ovf;
  logic          tbl_last;

  fibo_table #(.N(N), .W(W), .AW(AW)) u_table (
    .clk        (clk),
    .rst        (reset),
    .rd0_addr_i (t_q),
    .rd1_addr_i (t_b),
    .rd0_data_o (rd0_data),
    .rd1_data_o (rd1_data),
    .rd0_ovf_o  (rd0_ovf),
    .rd1_ovf_o  (rd1_ovf),
    .ready_o    (ready),
    .ovf_o      (ovf),
    .last_o     (tbl_last)
  );

  // One scroll step in the given direction, wrapping at both ends.
  function automatic logic [AW-1:0] step_index(input logic [AW-1:0] idx, input logic rev);
    if (rev) return (idx == '0) ? LAST_IDX : idx - 1'b1;
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // "Fxx:" label (1-based hex) followed by a 12-char right-aligned value or OVF.
  function automatic logic [127:0] format_row(input logic [AW-1:0] idx,
                                              input logic [W-1:0] value,
                                              input logic is_ovf);
    logic [127:0] r;
    logic [7:0]   label;
    r          = {16{ASCII_SPACE}};
    label      = 8'(idx) + 8'd1;
    r[127:120] = "F";
    r[119:112] = hex_to_ascii(label[7:4]);
    r[111:104] = hex_to_ascii(label[3:0]);
    r[103:96]  = ":";
    if (is_ovf) begin
      r[23:0] = OVF_STR;
    end else begin
      for (int d = 0; d < DIGITS; d++) r[8*d +: 8] = hex_to_ascii(value[4*d +: 4]);
    end
    return r;
  endfunction

  assign t_b = (t_q == LAST_IDX) ? '0 : t_q + 1'b1;

  // Next state, scroll index, period counter and direction.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    rev_d   = rev_q;
    do_step = 1'b0;
    case (state_q)
      ST_GEN: begin
        if (tbl_last) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (dir_pulse) begin
          state_d = ST_RUN;
          t_d     = '0;
          rev_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == PERIOD_MAX) begin
          cnt_d   = '0;
          do_step = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (dir_pulse)   rev_d   = ~rev_q;
        if (pause_pulse) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (step_pulse) do_step = 1'b1;
        if (dir_pulse)  rev_d   = ~rev_q;
        if (pause_pulse) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_GEN;
    endcase
    // The step always uses the direction in force before this edge.
    if (do_step) t_d = step_index(t_q, rev_q);
  end

  // Row contents for the next edge: banner until scrolling starts, then table text.
  always_comb begin
    row_a_d = BANNER_A;
    row_b_d = BANNER_B;
    if (state_q == ST_RUN || state_q == ST_PAUSE) begin
      row_a_d = format_row(t_q, rd0_data, rd0_ovf);
      row_b_d = format_row(t_b, rd1_data, rd1_ovf);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_GEN;
    else       state_q <= state_d;
  end

  // Scroll index, period counter and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q   <= '0;
      cnt_q <= '0;
      rev_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      cnt_q <= cnt_d;
      rev_q <= rev_d;
    end
  end

  // Registered LCD rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_a_q <= BANNER_A;
      row_b_q <= BANNER_B;
    end else begin
      row_a_q <= row_a_d;
      row_b_q <= row_b_d;
    end
  end

  assign row_A   = row_a_q;
  assign row_B   = row_b_q;
  assign running = (state_q == ST_RUN);
  assign reverse = rev_q;

endmodule

// File: tb/tb_fibo_scroller.sv
// Bench for fibo_scroller: N=25 instance for scrolling behaviour, N=27
// instance for overflow display. A string-based model produces expected rows.
module tb_fibo_scroller;

  localparam int NA  = 25;
  localparam int NB  = 27;
  localparam int WA  = 16;
  localparam int PER = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, dir_a, pause_a, step_a;
  logic [127:0] row_a_a, row_b_a;
  logic         ready_a, ovf_a, running_a, reverse_a;
  logic         rst_b, dir_b, pause_b, step_b;
  logic [127:0] row_a_b, row_b_b;
  logic         ready_b, ovf_b, running_b, reverse_b;

  fibo_scroller #(.N(NA), .W(WA), .PERIOD(PER)) dut_a (
    .clk(clk), .reset(rst_a), .dir_pulse(dir_a), .pause_pulse(pause_a), .step_pulse(step_a),
    .row_A(row_a_a), .row_B(row_b_a), .ready(ready_a), .ovf(ovf_a),
    .running(running_a), .reverse(reverse_a)
  );

  fibo_scroller #(.N(NB), .W(WA), .PERIOD(PER)) dut_b (
    .clk(clk), .reset(rst_b), .dir_pulse(dir_b), .pause_pulse(pause_b), .step_pulse(step_b),
    .row_A(row_a_b), .row_B(row_b_b), .ready(ready_b), .ovf(ovf_b),
    .running(running_b), .reverse(reverse_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [127:0] ban_a   = "Press BTN3 to   ";
  logic [127:0] ban_b   = "show a message..";
  logic [127:0] s_f01   = "F01:        0000";
  logic [127:0] s_f02   = "F02:        0001";
  logic [127:0] s_f03   = "F03:        0001";
  logic [127:0] s_f19   = "F19:        B520";
  logic [127:0] s_f1a_o = "F1A:         OVF";
  logic [127:0] s_f1b_o = "F1B:         OVF";

  // ---------------- reference model ----------------
  longint val_m [32];
  bit     ovf_m [32];
  int     t_m, el_m, mode_m;
  bit     rev_m;
  logic [127:0] exp_a, exp_b;

  task automatic build_model();
    val_m[0] = 0; ovf_m[0] = 0;
    val_m[1] = 1; ovf_m[1] = 0;
    for (int k = 2; k < 32; k++) begin
      if (ovf_m[k-1]) begin
        ovf_m[k] = 1; val_m[k] = 0;
      end else begin
        val_m[k] = val_m[k-1] + val_m[k-2];
        ovf_m[k] = (val_m[k] >= (64'd1 << WA));
      end
    end
  endtask

  function automatic logic [127:0] text_of(input int i);
    string hs = "0123456789ABCDEF";
    byte c [16];
    logic [127:0] r;
    for (int j = 0; j < 16; j++) c[j] = 8'h20;
    c[0] = "F";
    c[1] = hs[(i + 1) / 16];
    c[2] = hs[(i + 1) % 16];
    c[3] = ":";
    if (ovf_m[i]) begin
      c[13] = "O"; c[14] = "V"; c[15] = "F";
    end else begin
      for (int d = 0; d < WA / 4; d++) c[15 - d] = hs[int'((val_m[i] >> (4 * d)) & 15)];
    end
    for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = c[j];
    return r;
  endfunction

  // ---------------- driver ----------------
  // Computes the rows expected after the coming edge, advances the model, then drives one edge.
  task automatic drive_edge(input logic d, input logic p, input logic s);
    if (mode_m == M_IDLE) begin
      exp_a = ban_a; exp_b = ban_b;
    end else begin
      exp_a = text_of(t_m); exp_b = text_of((t_m + 1) % NA);
    end
    case (mode_m)
      M_IDLE: if (d) begin mode_m = M_RUN; t_m = 0; rev_m = 0; el_m = 0; end
      M_RUN: begin
        el_m++;
        if (el_m == PER) begin
          t_m  = rev_m ? (t_m + NA - 1) % NA : (t_m + 1) % NA;
          el_m = 0;
        end
        if (d) rev_m = !rev_m;
        if (p) mode_m = M_PAUSE;
      end
      default: begin
        if (s) t_m = rev_m ? (t_m + NA - 1) % NA : (t_m + 1) % NA;
        if (d) rev_m = !rev_m;
        if (p) begin mode_m = M_RUN; el_m = 0; end
      end
    endcase
    dir_a = d; pause_a = p; step_a = s;
    @(posedge clk); #1;
    dir_a = 0; pause_a = 0; step_a = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1; dir_a = 0; pause_a = 0; step_a = 0;
    rst_b = 1; dir_b = 0; pause_b = 0; step_b = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (row_a_a !== ban_a) begin failures++; $display("FAIL reset_row_A: got '%s' want '%s'", row_a_a, ban_a); end
    checks++; if (row_b_a !== ban_b) begin failures++; $display("FAIL reset_row_B: got '%s' want '%s'", row_b_a, ban_b); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf_a); end
    checks++; if (running_a !== 1'b0) begin failures++; $display("FAIL reset_running: got %b want 0", running_a); end
    checks++; if (reverse_a !== 1'b0) begin failures++; $display("FAIL reset_reverse: got %b want 0", reverse_a); end
    rst_a = 0;
    for (int e = 1; e <= NA - 1; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_a !== (e == NA - 1)) begin
        failures++; $display("FAIL gen_ready edge %0d: got %b want %b", e, ready_a, (e == NA - 1));
      end
    end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL gen_ovf: got %b want 0", ovf_a); end
    checks++; if (row_a_a !== ban_a) begin failures++; $display("FAIL idle_row_A: got '%s' want '%s'", row_a_a, ban_a); end
    mode_m = M_IDLE; t_m = 0; rev_m = 0; el_m = 0;
  endtask

  task automatic test_start();
    drive_edge(1, 0, 0);
    checks++; if (row_a_a !== exp_a) begin failures++; $display("FAIL start_entry_row_A: got '%s' want '%s'", row_a_a, exp_a); end
    checks++; if (running_a !== 1'b1) begin failures++; $display("FAIL start_running: got %b want 1", running_a); end
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== s_f01) begin failures++; $display("FAIL start_row_A: got '%s' want '%s'", row_a_a, s_f01); end
    checks++; if (row_b_a !== s_f02) begin failures++; $display("FAIL start_row_B: got '%s' want '%s'", row_b_a, s_f02); end
    for (int i = 0; i < PER; i++) begin
      drive_edge(0, 0, 0);
      checks++;
      if (row_a_a !== exp_a || row_b_a !== exp_b) begin
        failures++; $display("FAIL start_tick_rows cyc %0d: got '%s'/'%s' want '%s'/'%s'", i, row_a_a, row_b_a, exp_a, exp_b);
      end
    end
    checks++; if (row_a_a !== s_f02 || row_b_a !== s_f03) begin failures++; $display("FAIL first_tick_rows: got '%s'/'%s' want '%s'/'%s'", row_a_a, row_b_a, s_f02, s_f03); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 400 && t_m != NA - 1; i++) begin
      drive_edge(0, 0, 0);
      checks++;
      if (row_a_a !== exp_a || row_b_a !== exp_b) begin
        failures++; $display("FAIL fwd_rows: got '%s'/'%s' want '%s'/'%s'", row_a_a, row_b_a, exp_a, exp_b);
      end
    end
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== s_f19 || row_b_a !== s_f01) begin failures++; $display("FAIL top_rows: got '%s'/'%s' want '%s'/'%s'", row_a_a, row_b_a, s_f19, s_f01); end
    for (int i = 0; i < 20 && t_m != 0; i++) drive_edge(0, 0, 0);
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== s_f01) begin failures++; $display("FAIL fwd_wrap_row_A: got '%s' want '%s'", row_a_a, s_f01); end
    drive_edge(1, 0, 0);
    checks++; if (reverse_a !== 1'b1) begin failures++; $display("FAIL dir_toggle: got %b want 1", reverse_a); end
    for (int i = 0; i < 20 && t_m != NA - 1; i++) begin
      drive_edge(0, 0, 0);
      checks++;
      if (row_a_a !== exp_a) begin failures++; $display("FAIL rev_rows: got '%s' want '%s'", row_a_a, exp_a); end
    end
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== s_f19 || row_b_a !== s_f01) begin failures++; $display("FAIL rev_wrap_rows: got '%s'/'%s' want '%s'/'%s'", row_a_a, row_b_a, s_f19, s_f01); end
  endtask

  task automatic test_pause();
    drive_edge(0, 1, 0);
    checks++; if (running_a !== 1'b0) begin failures++; $display("FAIL pause_running: got %b want 0", running_a); end
    for (int i = 0; i < 100; i++) begin
      drive_edge(0, 0, 0);
      checks++;
      if (row_a_a !== exp_a || row_b_a !== exp_b || running_a !== 1'b0) begin
        failures++; $display("FAIL pause_hold cyc %0d: got '%s' run=%b want '%s' run=0", i, row_a_a, running_a, exp_a);
      end
    end
    drive_edge(0, 0, 1);
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== exp_a || row_b_a !== exp_b) begin failures++; $display("FAIL step_rows: got '%s'/'%s' want '%s'/'%s'", row_a_a, row_b_a, exp_a, exp_b); end
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== exp_a) begin failures++; $display("FAIL step_once: got '%s' want '%s'", row_a_a, exp_a); end
    drive_edge(0, 1, 0);
    checks++; if (running_a !== 1'b1) begin failures++; $display("FAIL resume_running: got %b want 1", running_a); end
    for (int i = 0; i < PER + 2; i++) begin
      drive_edge(0, 0, 0);
      checks++;
      if (row_a_a !== exp_a || row_b_a !== exp_b) begin
        failures++; $display("FAIL resume_rows cyc %0d: got '%s'/'%s' want '%s'/'%s'", i, row_a_a, row_b_a, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_edge(($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      checks++;
      if (row_a_a !== exp_a || row_b_a !== exp_b) begin
        failures++; $display("FAIL rand_rows cyc %0d: got '%s'/'%s' want '%s'/'%s'", i, row_a_a, row_b_a, exp_a, exp_b);
      end
      checks++;
      if (running_a !== (mode_m == M_RUN) || reverse_a !== rev_m) begin
        failures++; $display("FAIL rand_flags cyc %0d: got run=%b rev=%b want run=%b rev=%b", i, running_a, reverse_a, (mode_m == M_RUN), rev_m);
      end
    end
  endtask

  task automatic test_reset_midrun();
    if (mode_m == M_PAUSE) drive_edge(0, 1, 0);
    if (!rev_m) drive_edge(1, 0, 0);
    drive_edge(0, 0, 0);
    drive_edge(0, 0, 0);
    #3 rst_a = 1;
    #1;
    checks++; if (row_a_a !== ban_a || row_b_a !== ban_b) begin failures++; $display("FAIL midrst_rows: got '%s'/'%s' want banner", row_a_a, row_b_a); end
    checks++; if (ready_a !== 1'b0 || running_a !== 1'b0 || reverse_a !== 1'b0) begin failures++; $display("FAIL midrst_flags: got rdy=%b run=%b rev=%b want 0/0/0", ready_a, running_a, reverse_a); end
    @(posedge clk); #1;
    rst_a = 0;
    for (int e = 1; e <= NA - 1; e++) begin
      dir_a = 1'($urandom_range(0, 1)); pause_a = 1'($urandom_range(0, 1)); step_a = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      dir_a = 0; pause_a = 0; step_a = 0;
      checks++;
      if (ready_a !== (e == NA - 1) || running_a !== 1'b0 || reverse_a !== 1'b0) begin
        failures++; $display("FAIL regen edge %0d: got rdy=%b run=%b rev=%b want rdy=%b run=0 rev=0", e, ready_a, running_a, reverse_a, (e == NA - 1));
      end
    end
    mode_m = M_IDLE; t_m = 0; rev_m = 0; el_m = 0;
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== ban_a || running_a !== 1'b0) begin failures++; $display("FAIL regen_idle: got '%s' run=%b want banner run=0", row_a_a, running_a); end
    drive_edge(1, 0, 0);
    drive_edge(0, 0, 0);
    checks++; if (row_a_a !== s_f01 || row_b_a !== s_f02) begin failures++; $display("FAIL regen_start: got '%s'/'%s' want '%s'/'%s'", row_a_a, row_b_a, s_f01, s_f02); end
  endtask

  task automatic test_overflow();
    rst_b = 0;
    for (int e = 1; e <= NB - 1; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_b !== (e == NB - 1)) begin failures++; $display("FAIL ovf_gen_ready edge %0d: got %b want %b", e, ready_b, (e == NB - 1)); end
    end
    checks++; if (ovf_b !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", ovf_b); end
    dir_b = 1; @(posedge clk); #1; dir_b = 0;
    dir_b = 1; @(posedge clk); #1; dir_b = 0;
    checks++; if (reverse_b !== 1'b1) begin failures++; $display("FAIL ovf_reverse: got %b want 1", reverse_b); end
    repeat (PER) @(posedge clk);
    #1;
    checks++; if (row_a_b !== s_f1b_o || row_b_b !== s_f01) begin failures++; $display("FAIL ovf_rows_26: got '%s'/'%s' want '%s'/'%s'", row_a_b, row_b_b, s_f1b_o, s_f01); end
    repeat (PER) @(posedge clk);
    #1;
    checks++; if (row_a_b !== s_f1a_o || row_b_b !== s_f1b_o) begin failures++; $display("FAIL ovf_rows_25: got '%s'/'%s' want '%s'/'%s'", row_a_b, row_b_b, s_f1a_o, s_f1b_o); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_model();
    test_reset();
    test_start();
    test_wrap();
    test_pause();
    test_random();
    test_reset_midrun();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
